// File: rtl/array_regx_pkg.sv
// Shared definitions for the register-array family: read-collision modes,
// clear-engine state encoding and the lane-count helper.
package array_regx_pkg;

    // Read-during-write behaviour on a same-address collision
    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Clear engine states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } clr_state_e;

    // Number of write-enable lanes for a given entry and lane width
    function automatic int lane_count(input int width, input int lane);
        return width / lane;
    endfunction

endpackage

// File: rtl/array_regx_clr.sv
// Clear engine for the register array: walks a pointer over every entry,
// zeroing one per cycle, and owns the single effective write port so the
// sweep and user writes never compete for the array.
module array_regx_clr
    import array_regx_pkg::*;
#(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32,
    parameter int NLANE   = 4
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               clr,
    input  logic               we,
    input  logic [ADDRBIT-1:0] wa,
    input  logic [NLANE-1:0]   wbe,
    input  logic [WIDTH-1:0]   di,
    output logic               busy,
    output logic               eff_we,
    output logic [ADDRBIT-1:0] eff_wa,
    output logic [NLANE-1:0]   eff_wbe,
    output logic [WIDTH-1:0]   eff_di
);

    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

    clr_state_e         state_q, state_d;
    logic [ADDRBIT-1:0] ptr_q, ptr_d;

    // Next state: clr only starts a sweep from idle; the sweep ends after the last entry
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDRBIT'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // State and pointer registers; reset aborts any sweep in progress
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Write-port mux: the sweep owns the port while busy, user writes are dropped
    always_comb begin
        busy    = (state_q == ST_SWEEP);
        eff_we  = we;
        eff_wa  = wa;
        eff_wbe = wbe;
        eff_di  = di;
        if (busy) begin
            eff_we  = 1'b1;
            eff_wa  = ptr_q;
            eff_wbe = '1;
            eff_di  = '0;
        end
    end

endmodule

// File: rtl/array1wnr_regx.sv
// Register array with one byte-masked write port and NRD read ports,
// per-port valid strobes, selectable read-during-write behaviour, optional
// output register stage and a sequenced clear engine.
// The read-data bus is named do_ because "do" is a reserved word.
module array1wnr_regx
    import array_regx_pkg::*;
#(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32,
    parameter int LANE    = 8,
    parameter int NRD     = 2,
    parameter int RDMODE  = 0,
    parameter int OREG    = 0
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   clr,
    output logic                   busy,
    input  logic                   we,
    input  logic [ADDRBIT-1:0]     wa,
    input  logic [WIDTH/LANE-1:0]  wbe,
    input  logic [WIDTH-1:0]       di,
    input  logic [NRD-1:0]         re,
    input  logic [NRD*ADDRBIT-1:0] ra,
    output logic [NRD*WIDTH-1:0]   do_,
    output logic [NRD-1:0]         vld
);

    localparam int NLANE = lane_count(WIDTH, LANE);
    localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = ADDRBIT + 1;
    localparam logic [ADDRBIT:0] DEPTH_W = AW1'(DEPTH);

    logic               eff_we;
    logic [ADDRBIT-1:0] eff_wa;
    logic [NLANE-1:0]   eff_wbe;
    logic [WIDTH-1:0]   eff_di;
    logic [WIDTH-1:0]   wr_mask;
    logic               wr_hit;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    array_regx_clr #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .NLANE   (NLANE)
    ) u_clr (
        .clk     (clk),
        .rst_    (rst_),
        .clr     (clr),
        .we      (we),
        .wa      (wa),
        .wbe     (wbe),
        .di      (di),
        .busy    (busy),
        .eff_we  (eff_we),
        .eff_wa  (eff_wa),
        .eff_wbe (eff_wbe),
        .eff_di  (eff_di)
    );

    // Expand the lane mask to a bit mask and qualify the write against the table depth
    always_comb begin
        wr_mask = '0;
        for (int k = 0; k < NLANE; k++) begin
            wr_mask[k*LANE +: LANE] = {LANE{eff_wbe[k]}};
        end
        wr_hit = eff_we && ({1'b0, eff_wa} < DEPTH_W);
    end

    // Merge the masked lanes of the effective write into the addressed entry
    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[eff_wa[IDXW-1:0]] = (mem_q[eff_wa[IDXW-1:0]] & ~wr_mask) | (eff_di & wr_mask);
        end
    end

    // Array storage, cleared as a whole by reset
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDRBIT-1:0] rd_addr;
        logic [WIDTH-1:0]   rd_old;
        logic [WIDTH-1:0]   rd_data;
        logic [WIDTH-1:0]   do1_q, do1_d;
        logic               vld1_q, vld1_d;
        logic [WIDTH-1:0]   do_out;
        logic               vld_out;

        // Entry lookup with out-of-range zeroing and optional write-first bypass
        always_comb begin
            rd_addr = ra[p*ADDRBIT +: ADDRBIT];
            rd_old  = ({1'b0, rd_addr} < DEPTH_W) ? mem_q[rd_addr[IDXW-1:0]] : '0;
            rd_data = rd_old;
            if ((RDMODE == WR_FIRST) && wr_hit && (eff_wa == rd_addr)) begin
                rd_data = (rd_old & ~wr_mask) | (eff_di & wr_mask);
            end
            do1_d  = re[p] ? rd_data : do1_q;
            vld1_d = re[p];
        end

        // First read stage: data holds when the port is not enabled
        always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
                do1_q  <= '0;
                vld1_q <= 1'b0;
            end else begin
                do1_q  <= do1_d;
                vld1_q <= vld1_d;
            end
        end

        if (OREG != 0) begin : g_oreg
            logic [WIDTH-1:0] do2_q, do2_d;
            logic             vld2_q, vld2_d;

            // Second stage only loads when the first stage presents valid data
            always_comb begin
                do2_d  = vld1_q ? do1_q : do2_q;
                vld2_d = vld1_q;
            end

            // Optional output register stage
            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    do2_q  <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    do2_q  <= do2_d;
                    vld2_q <= vld2_d;
                end
            end

            assign do_out  = do2_q;
            assign vld_out = vld2_q;
        end else begin : g_noreg
            assign do_out  = do1_q;
            assign vld_out = vld1_q;
        end

        assign do_[p*WIDTH +: WIDTH] = do_out;
        assign vld[p]                = vld_out;
    end

endmodule

// File: tb/tb_array1wnr_regx.sv
// Bench for the register array: two instances share the stimulus, one
// read-first without output register, one write-first with output register.
// Expected read data is queued at issue time and checked when vld appears.
module tb_array1wnr_regx;

    localparam int AB = 5;
    localparam int DP = 16;
    localparam int W  = 32;
    localparam int NL = 4;
    localparam int NR = 2;

    typedef struct packed {
        logic [1:0]  en;
        logic [31:0] d1;
        logic [31:0] d0;
    } rd_item_t;

    logic           clk = 1'b0;
    logic           rst_;
    logic           clr;
    logic           we;
    logic [AB-1:0]  wa;
    logic [NL-1:0]  wbe;
    logic [W-1:0]   di;
    logic [NR-1:0]  re;
    logic [NR*AB-1:0] ra;

    logic           busyA, busyB;
    logic [NR*W-1:0] doA, doB;
    logic [NR-1:0]  vldA, vldB;

    rd_item_t expA[$];
    rd_item_t expB[$];
    logic [63:0] lastA = '0;
    logic [63:0] lastB = '0;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    array1wnr_regx #(
        .ADDRBIT(AB), .DEPTH(DP), .WIDTH(W), .LANE(8), .NRD(NR), .RDMODE(0), .OREG(0)
    ) dutA (
        .clk(clk), .rst_(rst_), .clr(clr), .busy(busyA), .we(we), .wa(wa), .wbe(wbe),
        .di(di), .re(re), .ra(ra), .do_(doA), .vld(vldA)
    );

    array1wnr_regx #(
        .ADDRBIT(AB), .DEPTH(DP), .WIDTH(W), .LANE(8), .NRD(NR), .RDMODE(1), .OREG(1)
    ) dutB (
        .clk(clk), .rst_(rst_), .clr(clr), .busy(busyB), .we(we), .wa(wa), .wbe(wbe),
        .di(di), .re(re), .ra(ra), .do_(doB), .vld(vldB)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkItem(input string tag, input rd_item_t it, input logic [1:0] vldv,
                             input logic [63:0] dov, inout logic [63:0] last);
        logic [31:0] e;
        checkOutput({tag, " vld"}, 32'(vldv), 32'(it.en));
        for (int p = 0; p < 2; p++) begin
            if (it.en[p]) e = (p == 0) ? it.d0 : it.d1;
            else          e = last[p*32 +: 32];
            checkOutput($sformatf("%s port%0d data", tag, p), dov[p*32 +: 32], e);
            last[p*32 +: 32] = e;
        end
    endtask

    // Monitor for the read-first instance
    always @(negedge clk) begin
        if (vldA != '0) begin
            if (expA.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL A unexpected vld: got %b expected 00", vldA);
            end else begin
                checkItem("A", expA.pop_front(), vldA, doA, lastA);
            end
        end
    end

    // Monitor for the write-first, registered-output instance
    always @(negedge clk) begin
        if (vldB != '0) begin
            if (expB.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL B unexpected vld: got %b expected 00", vldB);
            end else begin
                checkItem("B", expB.pop_front(), vldB, doB, lastB);
            end
        end
    end

    task automatic applyStimulus(input logic iwe, input logic [AB-1:0] iwa, input logic [NL-1:0] iwbe,
                                 input logic [W-1:0] idi, input logic [1:0] ire,
                                 input logic [AB-1:0] ira0, input logic [AB-1:0] ira1, input logic iclr);
        we  = iwe;
        wa  = iwa;
        wbe = iwbe;
        di  = idi;
        re  = ire;
        ra  = {ira1, ira0};
        clr = iclr;
        @(posedge clk);
        #1;
        we  = 1'b0;
        re  = '0;
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    task automatic doWrite(input logic [AB-1:0] a, input logic [NL-1:0] be, input logic [W-1:0] d);
        applyStimulus(1, a, be, d, 2'b00, 0, 0, 0);
    endtask

    task automatic pushExp(input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] b0, input logic [31:0] b1);
        expA.push_back('{en: en, d1: a1, d0: a0});
        expB.push_back('{en: en, d1: b1, d0: b0});
    endtask

    task automatic doRead(input logic [1:0] en, input logic [AB-1:0] a0, input logic [AB-1:0] a1,
                          input logic [31:0] e0, input logic [31:0] e1);
        pushExp(en, e0, e1, e0, e1);
        applyStimulus(0, 0, 0, 0, en, a0, a1, 0);
    endtask

    initial begin
        int cntA;
        int cntB;
        rst_ = 1'b0;
        clr  = 1'b0;
        we   = 1'b0;
        wa   = '0;
        wbe  = '0;
        di   = '0;
        re   = '0;
        ra   = '0;

        // Reset state
        #2;
        checkOutput("reset busyA", 32'(busyA), 32'd0);
        checkOutput("reset busyB", 32'(busyB), 32'd0);
        checkOutput("reset vldA", 32'(vldA), 32'd0);
        checkOutput("reset vldB", 32'(vldB), 32'd0);
        checkOutput("reset doA", doA[31:0] | doA[63:32], 32'd0);
        checkOutput("reset doB", doB[31:0] | doB[63:32], 32'd0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;

        // Mid-cycle reset clears held read data and the stored entry
        doWrite(5, 4'hF, 32'hDEADBEEF);
        doRead(2'b11, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF);
        idle(2);
        checkOutput("hold doA before reset", doA[31:0], 32'hDEADBEEF);
        checkOutput("hold doB before reset", doB[63:32], 32'hDEADBEEF);
        #2;
        rst_ = 1'b0;
        #1;
        checkOutput("async reset doA", doA[31:0] | doA[63:32], 32'd0);
        checkOutput("async reset doB", doB[31:0] | doB[63:32], 32'd0);
        checkOutput("async reset vldA", 32'(vldA), 32'd0);
        checkOutput("async reset vldB", 32'(vldB), 32'd0);
        lastA = '0;
        lastB = '0;
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        doRead(2'b11, 5, 5, 32'h0, 32'h0);
        idle(2);

        // Lane mask merge and read latency
        doWrite(3, 4'hF, 32'h11223344);
        doWrite(3, 4'b0101, 32'hAABBCCDD);
        doRead(2'b11, 3, 3, 32'h11BB33DD, 32'h11BB33DD);
        checkOutput("latency vldA edge1", 32'(vldA), 32'd3);
        checkOutput("latency vldB edge1", 32'(vldB), 32'd0);
        idle(1);
        checkOutput("latency vldA edge2", 32'(vldA), 32'd0);
        checkOutput("latency vldB edge2", 32'(vldB), 32'd3);
        idle(1);

        // Same-address collision on both ports
        doWrite(7, 4'hF, 32'h1);
        pushExp(2'b11, 32'h1, 32'h1, 32'h2, 32'h2);
        applyStimulus(1, 7, 4'hF, 32'h2, 2'b11, 7, 7, 0);
        doRead(2'b11, 7, 7, 32'h2, 32'h2);
        idle(2);

        // Out-of-range reads, disabled ports holding, ignored writes
        doWrite(0, 4'hF, 32'h0000CAFE);
        doRead(2'b11, 16, 3, 32'h0, 32'h11BB33DD);
        doRead(2'b01, 7, 0, 32'h2, 32'h0);
        doRead(2'b10, 0, 7, 32'h0, 32'h2);
        doWrite(16, 4'hF, 32'h55555555);
        doWrite(3, 4'h0, 32'hFFFFFFFF);
        doRead(2'b11, 0, 3, 32'h0000CAFE, 32'h11BB33DD);
        idle(3);

        // Clear sweep: busy span, dropped write, ignored second clr, reads mid-sweep
        for (int i = 0; i < DP; i++) doWrite(AB'(i), 4'hF, 32'hFFFFFFFF);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 1);
        for (int k = 0; k < DP; k++) begin
            checkOutput($sformatf("sweep busyA cycle %0d", k), 32'(busyA), 32'd1);
            checkOutput($sformatf("sweep busyB cycle %0d", k), 32'(busyB), 32'd1);
            if (k == 2) begin
                doRead(2'b11, 0, 15, 32'h0, 32'hFFFFFFFF);
            end else if (k == 4) begin
                doWrite(2, 4'hF, 32'h12345678);
            end else if (k == 6) begin
                applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 1);
            end else begin
                idle(1);
            end
        end
        checkOutput("sweep end busyA", 32'(busyA), 32'd0);
        checkOutput("sweep end busyB", 32'(busyB), 32'd0);
        idle(2);
        for (int i = 0; i < DP / 2; i++) doRead(2'b11, AB'(2*i), AB'(2*i+1), 32'h0, 32'h0);
        idle(3);

        // Reset in the middle of a sweep, then a full fresh sweep
        doWrite(9, 4'hF, 32'hA5A5A5A5);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 1);
        idle(6);
        #2;
        rst_ = 1'b0;
        #1;
        checkOutput("mid-sweep reset busyA", 32'(busyA), 32'd0);
        checkOutput("mid-sweep reset busyB", 32'(busyB), 32'd0);
        lastA = '0;
        lastB = '0;
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        doRead(2'b11, 9, 9, 32'h0, 32'h0);
        idle(3);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 1);
        cntA = 0;
        cntB = 0;
        for (int i = 0; i < 40; i++) begin
            if (busyA) cntA++;
            if (busyB) cntB++;
            idle(1);
        end
        checkOutput("restart sweep length A", 32'(cntA), 32'd16);
        checkOutput("restart sweep length B", 32'(cntB), 32'd16);

        // Every queued read must have been answered
        idle(3);
        checkOutput("pending reads A", 32'(expA.size()), 32'd0);
        checkOutput("pending reads B", 32'(expB.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
